// File: rtl/mic1_pkg.sv
// Shared MIC-1 datapath encodings: B-bus selects, C-enable and memCtrl bit positions.
package mic1_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int MBR_WIDTH_DEF  = 8;

    typedef enum logic [3:0] {
        B_MDR  = 4'd0,
        B_PC   = 4'd1,
        B_MBR  = 4'd2,
        B_MBRU = 4'd3,
        B_SP   = 4'd4,
        B_LV   = 4'd5,
        B_CPP  = 4'd6,
        B_TOS  = 4'd7,
        B_OPC  = 4'd8
    } bsel_e;

    localparam int C_MAR = 0;
    localparam int C_MDR = 1;
    localparam int C_PC  = 2;
    localparam int C_SP  = 3;
    localparam int C_LV  = 4;
    localparam int C_CPP = 5;
    localparam int C_TOS = 6;
    localparam int C_OPC = 7;
    localparam int C_H   = 8;

    localparam int M_FETCH = 0;
    localparam int M_READ  = 1;
    localparam int M_WRITE = 2;

endpackage

// File: rtl/mem_handshake.sv
// Memory rd/wr/fetch strobes, outstanding-request tracking and protocol error detection.
module mem_handshake import mic1_pkg::*; #(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int MAX_PENDING = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            memCtrl,
    input  logic [DATA_WIDTH-1:0] marNext,
    input  logic [DATA_WIDTH-1:0] mdrNext,
    input  logic [DATA_WIDTH-1:0] pcNext,
    input  logic                  memReadValid,
    input  logic                  fetchValid,
    output logic                  readAccept,
    output logic                  fetchAccept,
    output logic [DATA_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic [DATA_WIDTH-1:0] fetchAddr,
    output logic                  memRead,
    output logic                  memWrite,
    output logic                  fetchReq,
    output logic                  protocolError
);

    logic [1:0]            pend_q, pend_d;
    logic                  fpend_q, fpend_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, faddr_q, faddr_d;
    logic                  rd_q, wr_q, freq_q, err_q;
    logic                  do_rd_s, do_wr_s, do_fetch_s, rd_full_s, err_s;

    // Request arbitration, pending bookkeeping and next-state for the strobes.
    always_comb begin
        do_wr_s     = memCtrl[M_WRITE];
        rd_full_s   = (pend_q == 2'(MAX_PENDING));
        do_rd_s     = memCtrl[M_READ] && !do_wr_s && !rd_full_s;
        do_fetch_s  = memCtrl[M_FETCH] && !fpend_q;
        readAccept  = memReadValid && (pend_q != 2'd0);
        fetchAccept = fetchValid && fpend_q;
        err_s       = (memCtrl[M_READ] && (do_wr_s || rd_full_s))
                    || (memCtrl[M_FETCH] && fpend_q)
                    || (memReadValid && !readAccept)
                    || (fetchValid && !fetchAccept);
        pend_d      = pend_q + {1'b0, do_rd_s} - {1'b0, readAccept};
        if (do_fetch_s) begin
            fpend_d = 1'b1;
        end else if (fetchAccept) begin
            fpend_d = 1'b0;
        end else begin
            fpend_d = fpend_q;
        end
        addr_d  = (do_wr_s || do_rd_s) ? marNext : addr_q;
        wdata_d = do_wr_s ? mdrNext : wdata_q;
        faddr_d = do_fetch_s ? pcNext : faddr_q;
    end

    // Handshake state and registered strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q  <= 2'd0;
            fpend_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            faddr_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            freq_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            fpend_q <= fpend_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            faddr_q <= faddr_d;
            rd_q    <= do_rd_s;
            wr_q    <= do_wr_s;
            freq_q  <= do_fetch_s;
            err_q   <= err_s;
        end
    end

    assign memAddr       = addr_q;
    assign memWriteData  = wdata_q;
    assign fetchAddr     = faddr_q;
    assign memRead       = rd_q;
    assign memWrite      = wr_q;
    assign fetchReq      = freq_q;
    assign protocolError = err_q;

endmodule

// File: rtl/register_bank.sv
// MIC-1 register bank: C-bus writes, B-bus/H sources and the memory handshake.
// Optional REG_BANK_FORWARD_EN bypasses same-cycle C-bus writes onto bBus/hOut.
module register_bank import mic1_pkg::*; #(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int MBR_WIDTH   = MBR_WIDTH_DEF,
    parameter int MAX_PENDING = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [8:0]            cEnable,
    input  logic [DATA_WIDTH-1:0] cData,
    input  logic [3:0]            bSelect,
    input  logic [2:0]            memCtrl,
    output logic [DATA_WIDTH-1:0] bBus,
    output logic [DATA_WIDTH-1:0] hOut,
    output logic [DATA_WIDTH-1:0] memAddr,
    output logic                  memRead,
    output logic                  memWrite,
    output logic [DATA_WIDTH-1:0] memWriteData,
    input  logic [DATA_WIDTH-1:0] memReadData,
    input  logic                  memReadValid,
    output logic [DATA_WIDTH-1:0] fetchAddr,
    output logic                  fetchReq,
    input  logic [MBR_WIDTH-1:0]  fetchData,
    input  logic                  fetchValid,
    output logic                  protocolError
);

    logic [DATA_WIDTH-1:0] mar_q, mdr_q, pc_q, sp_q, lv_q, cpp_q, tos_q, opc_q, h_q;
    logic [DATA_WIDTH-1:0] mar_d, mdr_d, pc_d, sp_d, lv_d, cpp_d, tos_d, opc_d, h_d;
    logic [MBR_WIDTH-1:0]  mbr_q, mbr_d;
    logic [DATA_WIDTH-1:0] b_reg_s;
    logic                  read_accept_s, fetch_accept_s;

    // Next-state: returning memory data takes priority over a same-cycle C-bus write.
    always_comb begin
        mar_d = cEnable[C_MAR] ? cData : mar_q;
        pc_d  = cEnable[C_PC]  ? cData : pc_q;
        sp_d  = cEnable[C_SP]  ? cData : sp_q;
        lv_d  = cEnable[C_LV]  ? cData : lv_q;
        cpp_d = cEnable[C_CPP] ? cData : cpp_q;
        tos_d = cEnable[C_TOS] ? cData : tos_q;
        opc_d = cEnable[C_OPC] ? cData : opc_q;
        h_d   = cEnable[C_H]   ? cData : h_q;
        if (read_accept_s) begin
            mdr_d = memReadData;
        end else begin
            mdr_d = cEnable[C_MDR] ? cData : mdr_q;
        end
        mbr_d = fetch_accept_s ? fetchData : mbr_q;
    end

    // Register storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            mar_q <= '0; mdr_q <= '0; pc_q  <= '0; sp_q  <= '0; lv_q <= '0;
            cpp_q <= '0; tos_q <= '0; opc_q <= '0; h_q   <= '0; mbr_q <= '0;
        end else begin
            mar_q <= mar_d; mdr_q <= mdr_d; pc_q  <= pc_d;  sp_q  <= sp_d;  lv_q <= lv_d;
            cpp_q <= cpp_d; tos_q <= tos_d; opc_q <= opc_d; h_q   <= h_d;   mbr_q <= mbr_d;
        end
    end

    // B-bus source mux from registered state.
    always_comb begin
        case (bSelect)
            B_MDR:   b_reg_s = mdr_q;
            B_PC:    b_reg_s = pc_q;
            B_MBR:   b_reg_s = {{(DATA_WIDTH-MBR_WIDTH){mbr_q[MBR_WIDTH-1]}}, mbr_q};
            B_MBRU:  b_reg_s = {{(DATA_WIDTH-MBR_WIDTH){1'b0}}, mbr_q};
            B_SP:    b_reg_s = sp_q;
            B_LV:    b_reg_s = lv_q;
            B_CPP:   b_reg_s = cpp_q;
            B_TOS:   b_reg_s = tos_q;
            B_OPC:   b_reg_s = opc_q;
            default: b_reg_s = '0;
        endcase
    end

`ifdef REG_BANK_FORWARD_EN
    logic fwd_s;

    // Bypass hit: the selected register is being written this cycle (MBR has no C-bus port).
    always_comb begin
        case (bSelect)
            B_MDR:   fwd_s = cEnable[C_MDR];
            B_PC:    fwd_s = cEnable[C_PC];
            B_SP:    fwd_s = cEnable[C_SP];
            B_LV:    fwd_s = cEnable[C_LV];
            B_CPP:   fwd_s = cEnable[C_CPP];
            B_TOS:   fwd_s = cEnable[C_TOS];
            B_OPC:   fwd_s = cEnable[C_OPC];
            default: fwd_s = 1'b0;
        endcase
    end

    assign bBus = fwd_s ? cData : b_reg_s;
    assign hOut = cEnable[C_H] ? cData : h_q;
`else
    assign bBus = b_reg_s;
    assign hOut = h_q;
`endif

    mem_handshake #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MAX_PENDING (MAX_PENDING)
    ) u_mem_handshake (
        .clock         (clock),
        .reset         (reset),
        .memCtrl       (memCtrl),
        .marNext       (mar_d),
        .mdrNext       (mdr_d),
        .pcNext        (pc_d),
        .memReadValid  (memReadValid),
        .fetchValid    (fetchValid),
        .readAccept    (read_accept_s),
        .fetchAccept   (fetch_accept_s),
        .memAddr       (memAddr),
        .memWriteData  (memWriteData),
        .fetchAddr     (fetchAddr),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .fetchReq      (fetchReq),
        .protocolError (protocolError)
    );

endmodule

// File: tb/tb_register_bank.sv
// Directed testbench for register_bank (default MAX_PENDING=1; honours REG_BANK_FORWARD_EN).
module tb_register_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  cEnable;
    logic [31:0] cData;
    logic [3:0]  bSelect;
    logic [2:0]  memCtrl;
    logic [31:0] bBus, hOut, memAddr, memWriteData, memReadData, fetchAddr;
    logic        memRead, memWrite, memReadValid, fetchReq, fetchValid, protocolError;
    logic [7:0]  fetchData;

    int n_vec = 0;
    int n_err = 0;

    register_bank dut (
        .clock         (clock),
        .reset         (reset),
        .cEnable       (cEnable),
        .cData         (cData),
        .bSelect       (bSelect),
        .memCtrl       (memCtrl),
        .bBus          (bBus),
        .hOut          (hOut),
        .memAddr       (memAddr),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .memWriteData  (memWriteData),
        .memReadData   (memReadData),
        .memReadValid  (memReadValid),
        .fetchAddr     (fetchAddr),
        .fetchReq      (fetchReq),
        .fetchData     (fetchData),
        .fetchValid    (fetchValid),
        .protocolError (protocolError)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic [3:0] sel, input logic [31:0] exp);
        bSelect = sel;
        #1;
        check(tag, bBus, exp);
    endtask

    task automatic idle();
        cEnable      = 9'h000;
        memCtrl      = 3'b000;
        memReadValid = 1'b0;
        fetchValid   = 1'b0;
    endtask

    initial begin
        logic [3:0] bsel_tab [9];
        logic [31:0] sp_exp;
        bsel_tab = '{4'd15, 4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd15};

        reset = 1'b1; cEnable = 9'h1FF; cData = 32'hFFFFFFFF; bSelect = 4'd0;
        memCtrl = 3'b000; memReadData = 32'h0; memReadValid = 1'b0;
        fetchData = 8'h00; fetchValid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        idle();
        for (int s = 0; s < 16; s++) check_b("reset_bbus", 4'(s), 32'h0);
        check("reset_h", hOut, 32'h0);
        check("reset_strobes", {28'h0, memRead, memWrite, fetchReq, protocolError}, 32'h0);
        check("reset_addr", memAddr | memWriteData | fetchAddr, 32'h0);

        cEnable = 9'h1 << 6; cData = 32'h12345678;
        tick(); idle();
        check_b("tos_write", 4'd7, 32'h12345678);

        for (int i = 0; i < 9; i++) begin
            if (i != 6) begin
                cEnable = 9'h1 << i; cData = 32'hA0 + i;
                tick(); idle();
                if (i == 8) check("h_write", hOut, 32'hA8);
                else if (i != 0) check_b("c_write", bsel_tab[i], 32'hA0 + i);
            end
        end
        check_b("tos_kept", 4'd7, 32'h12345678);

        memCtrl = 3'b001;
        tick(); idle();
        check("fetch_req", {31'h0, fetchReq}, 32'h1);
        check("fetch_addr", fetchAddr, 32'hA2);
        fetchValid = 1'b1; fetchData = 8'h80;
        tick(); idle();
        check("fetch_req_drop", {31'h0, fetchReq}, 32'h0);
        check("fetch_no_err", {31'h0, protocolError}, 32'h0);
        check_b("mbr_sext", 4'd2, 32'hFFFFFF80);
        check_b("mbru_zext", 4'd3, 32'h00000080);

        cEnable = 9'h001; cData = 32'h40; memCtrl = 3'b010;
        tick(); idle();
        check("rd_strobe", {31'h0, memRead}, 32'h1);
        check("rd_addr", memAddr, 32'h40);
        check("rd_no_err", {31'h0, protocolError}, 32'h0);
        tick();
        check("rd_strobe_drop", {31'h0, memRead}, 32'h0);
        memReadValid = 1'b1; memReadData = 32'hCAFEF00D; cEnable = 9'h002; cData = 32'h1;
        tick(); idle();
        check_b("mdr_mem_wins", 4'd0, 32'hCAFEF00D);
        check("rd_valid_no_err", {31'h0, protocolError}, 32'h0);

        memCtrl = 3'b010;
        tick();
        check("rd2_strobe", {31'h0, memRead}, 32'h1);
        check("rd2_no_err", {31'h0, protocolError}, 32'h0);
        tick(); idle();
        check("rd_full_drop", {31'h0, memRead}, 32'h0);
        check("rd_full_err", {31'h0, protocolError}, 32'h1);
        memReadValid = 1'b1; memReadData = 32'h11111111;
        tick();
        check("rd2_valid_no_err", {31'h0, protocolError}, 32'h0);
        memReadData = 32'h22222222;
        tick(); idle();
        check("unsolicited_err", {31'h0, protocolError}, 32'h1);
        check_b("unsolicited_mdr", 4'd0, 32'h11111111);
        tick();
        check("err_pulse_end", {31'h0, protocolError}, 32'h0);

        memCtrl = 3'b110; cEnable = 9'h003; cData = 32'h55;
        tick(); idle();
        check("rdwr_write", {31'h0, memWrite}, 32'h1);
        check("rdwr_read", {31'h0, memRead}, 32'h0);
        check("rdwr_err", {31'h0, protocolError}, 32'h1);
        check("wr_addr", memAddr, 32'h55);
        check("wr_data", memWriteData, 32'h55);
        tick();
        check("wr_strobe_drop", {31'h0, memWrite}, 32'h0);

        memCtrl = 3'b001;
        tick();
        check("fetch2_req", {31'h0, fetchReq}, 32'h1);
        tick(); idle();
        check("fetch_busy_drop", {31'h0, fetchReq}, 32'h0);
        check("fetch_busy_err", {31'h0, protocolError}, 32'h1);
        fetchValid = 1'b1; fetchData = 8'h7F;
        tick(); idle();
        check("fetch2_no_err", {31'h0, protocolError}, 32'h0);
        check_b("mbr_pos", 4'd2, 32'h0000007F);

`ifdef REG_BANK_FORWARD_EN
        sp_exp = 32'h99;
`else
        sp_exp = 32'hA3;
`endif
        cEnable = 9'h1 << 3; cData = 32'h99;
        check_b("sp_forward", 4'd4, sp_exp);
        tick(); idle();
        check_b("sp_written", 4'd4, 32'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- MIC-1 datapath register bank: the receiving end of the C bus driven by the ALU/shifter, and the source of the B bus and H that feed the ALU.
- Holds MAR, MDR, PC, MBR, SP, LV, CPP, TOS, OPC and H.
- Decodes the microinstruction C-enable and B-select fields.
- Runs the rd/wr/fetch handshake to main memory and loads MDR/MBR from returned data.

Parameters:
- DATA_WIDTH, 32, width of the C/B buses and of every register except MBR.
- MBR_WIDTH, 8, width of MBR and the fetch data port.
- MAX_PENDING, 1, outstanding data reads allowed (1 or 2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cEnable  in  9  one-hot-per-register C-bus write enables {H,OPC,TOS,CPP,LV,SP,PC,MDR,MAR}.
- cData  in  DATA_WIDTH  C bus (shifter output).
- bSelect  in  4  B-bus source: 0 MDR, 1 PC, 2 MBR (sign-extended), 3 MBRU (zero-extended), 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC, 9-15 zero.
- memCtrl  in  3  {write, read, fetch} microinstruction bits.
- bBus  out  DATA_WIDTH  B bus to the ALU.
- hOut  out  DATA_WIDTH  H register to the ALU A input.
- memAddr  out  DATA_WIDTH  word address for data access.
- memRead  out  1  one-cycle data read strobe.
- memWrite  out  1  one-cycle data write strobe.
- memWriteData  out  DATA_WIDTH  data for the write.
- memReadData  in  DATA_WIDTH  returned read data.
- memReadValid  in  1  memReadData is valid this cycle.
- fetchAddr  out  DATA_WIDTH  byte address for the instruction fetch.
- fetchReq  out  1  one-cycle fetch strobe.
- fetchData  in  MBR_WIDTH  returned instruction byte.
- fetchValid  in  1  fetchData is valid this cycle.
- protocolError  out  1  one-cycle pulse flagging an illegal memory request.

Behaviour:
- Reset: all registers, memAddr, memWriteData, fetchAddr, all strobes, protocolError and pending counters go to 0; pending transactions are abandoned, and any valids arriving after reset are ignored until a new request is issued.
- C-bus write: at each rising edge, every register whose cEnable bit is set loads cData. Multiple enables in one cycle are legal.
- bBus and hOut: combinational from current register state; there is no write-to-read forwarding unless the optional feature is enabled.
- MBR extension: MBR sign-extends MBR[MBR_WIDTH-1]; MBRU zero-extends.
- Memory requests: issued at the edge ending the microinstruction and use post-write values, so "MAR=SP; rd" addresses the new MAR.
  - read: next cycle memRead=1, memAddr = new MAR; pending read count increments.
  - write: next cycle memWrite=1, memAddr = new MAR, memWriteData = new MDR.
  - fetch: next cycle fetchReq=1, fetchAddr = new PC; fetch pending is set.
- Read and write in the same microinstruction: write is issued, read is dropped, protocolError pulses.
- Read while pending count == MAX_PENDING: read is dropped, protocolError pulses. The same rule applies to a fetch while a fetch is pending (one outstanding fetch).
- memReadValid: MDR <= memReadData and pending count decrements. If a C-bus MDR write lands in the same cycle, memory data wins.
- fetchValid: MBR <= fetchData and fetch pending clears; same priority rule as MDR.
- Unsolicited valid (nothing pending): ignored and protocolError pulses.
- Read and write pending concurrently is legal. Memory order is the issue order; the block does no hazard checking.

Optional Feature:
- Macro: REG_BANK_FORWARD_EN.
- Defined: bBus and hOut forward cData when the selected register's cEnable bit is set in the same cycle (bypass path; MBR/MBRU never forwarded).
- Undefined: outputs reflect the registered value only.

Decomposition:
- Shared package mic1_pkg holds:
  - B-select encodings (B_MDR..B_OPC);
  - cEnable bit indices;
  - memCtrl bit indices;
  - DATA_WIDTH and MBR_WIDTH defaults.
- One natural sub-module: mem_handshake, covering the pending counters, strobe generation and error detection. Register storage and the B mux stay in the top level.

Test Plan:
- Reset: hold reset 2 cycles with cEnable=9'h1FF and cData=32'hFFFFFFFF. All registers read 0 via every bSelect, hOut=0, all strobes 0.
- C-bus write: cEnable=TOS bit, cData=32'h12345678, then bSelect=7 -> bBus=32'h12345678. Set every other bit individually and check hOut for H.
- MBR extension: fetchValid with fetchData=8'h80. bSelect=2 -> 32'hFFFFFF80; bSelect=3 -> 32'h00000080.
- Read handshake: "MAR=cData(32'h40); rd" -> next cycle memRead=1, memAddr=32'h40. memReadValid with 32'hCAFEF00D two cycles later -> MDR=32'hCAFEF00D and pending clears. A concurrent C-bus MDR write=32'h1 loses.
- Errors: memCtrl=3'b110 -> memWrite=1, memRead=0, protocolError=1. With MAX_PENDING=1, a second rd before valid -> protocolError=1. memReadValid with nothing pending -> protocolError=1 and MDR unchanged.
- Forwarding: cEnable=SP with cData=32'h99 and bSelect=4 in the same cycle -> bBus=32'h99 with REG_BANK_FORWARD_EN, previous SP without it.
